// File: rtl/fc_ctrl_pkg.sv
// Shared types and constants for the fully connected layer sequencer.
package fc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int CORE_LATENCY = 2;
  localparam int BRAM_LATENCY = 1;

  // Address widths never collapse to zero bits, even for single-entry memories.
  function automatic int clog2w(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Input-index, output-index and running weight-pointer counters for the layer walk.
module fc_addr_gen
  import fc_ctrl_pkg::*;
#(
  parameter int IN_NODE   = 16,
  parameter int OUT_NODE  = 10,
  parameter int NODE_AW   = clog2w(IN_NODE),
  parameter int WEIGHT_AW = clog2w(IN_NODE * OUT_NODE),
  parameter int RES_AW    = clog2w(OUT_NODE)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_all,
  input  logic                 clear_in,
  input  logic                 step_in,
  input  logic                 step_out,
  output logic [NODE_AW-1:0]   in_idx,
  output logic [RES_AW-1:0]    out_idx,
  output logic [WEIGHT_AW-1:0] w_ptr,
  output logic                 last_in,
  output logic                 last_out
);

  localparam logic [NODE_AW-1:0]   LAST_IN_IDX  = NODE_AW'(IN_NODE - 1);
  localparam logic [RES_AW-1:0]    LAST_OUT_IDX = RES_AW'(OUT_NODE - 1);
  localparam logic [WEIGHT_AW-1:0] LAST_W_PTR   = WEIGHT_AW'(IN_NODE * OUT_NODE - 1);

  assign last_in  = (in_idx == LAST_IN_IDX);
  assign last_out = (out_idx == LAST_OUT_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_idx  <= '0;
      out_idx <= '0;
      w_ptr   <= '0;
    end else if (clear_all) begin
      in_idx  <= '0;
      out_idx <= '0;
      w_ptr   <= '0;
    end else begin
      if (clear_in) begin
        in_idx <= '0;
      end else if (step_in) begin
        in_idx <= last_in ? '0 : in_idx + 1'b1;
      end
      // The weight pointer runs across neuron boundaries; only a new layer rewinds it.
      if (step_in) begin
        w_ptr <= (w_ptr == LAST_W_PTR) ? '0 : w_ptr + 1'b1;
      end
      if (step_out) begin
        out_idx <= last_out ? '0 : out_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc_layer_controller.sv
// Sequencer walking every output neuron of one FC layer through a single MAC core:
// clear, stream operands from BRAM, wait out the core pipe, write the result.
module fc_layer_controller
  import fc_ctrl_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8,
  parameter int IN_NODE       = 16,
  parameter int OUT_NODE      = 10,
  parameter int NODE_AW       = clog2w(IN_NODE),
  parameter int WEIGHT_AW     = clog2w(IN_NODE * OUT_NODE),
  parameter int RES_AW        = clog2w(OUT_NODE)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NODE_AW-1:0]         node_addr_o,
  input  logic [IN_DATA_WIDTH-1:0]   node_rdata_i,
  output logic [WEIGHT_AW-1:0]       weight_addr_o,
  input  logic [IN_DATA_WIDTH-1:0]   weight_rdata_i,
  output logic                       core_run_o,
  output logic                       core_valid_o,
  output logic [IN_DATA_WIDTH-1:0]   core_node_o,
  output logic [IN_DATA_WIDTH-1:0]   core_weight_o,
  input  logic                       core_valid_i,
  input  logic [4*IN_DATA_WIDTH-1:0] core_result_i,
  output logic                       res_we_o,
  output logic [RES_AW-1:0]          res_addr_o,
  output logic [4*IN_DATA_WIDTH-1:0] res_data_o
);

  localparam int CNT_W = clog2w(IN_NODE + 1);
  localparam logic [CNT_W-1:0] LAST_RET = CNT_W'(IN_NODE - 1);

  state_e state, state_n;
  logic clear_all, clear_in, step_in, step_out, capture;
  logic last_in, last_out;
  logic [NODE_AW-1:0]      in_idx;
  logic [RES_AW-1:0]       out_idx;
  logic [WEIGHT_AW-1:0]    w_ptr;
  logic [BRAM_LATENCY-1:0] rd_pipe;
  logic [CORE_LATENCY-1:0] flight_pipe;
  logic [CNT_W-1:0]        ret_cnt;
  logic                    issue, count_en, ret_last;

  fc_addr_gen #(
    .IN_NODE   (IN_NODE),
    .OUT_NODE  (OUT_NODE),
    .NODE_AW   (NODE_AW),
    .WEIGHT_AW (WEIGHT_AW),
    .RES_AW    (RES_AW)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_all (clear_all),
    .clear_in  (clear_in),
    .step_in   (step_in),
    .step_out  (step_out),
    .in_idx    (in_idx),
    .out_idx   (out_idx),
    .w_ptr     (w_ptr),
    .last_in   (last_in),
    .last_out  (last_out)
  );

  assign issue    = (state == ST_FEED);
  assign count_en = core_valid_i && ((state == ST_FEED) || (state == ST_DRAIN));
  assign ret_last = core_valid_i && (ret_cnt == LAST_RET);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    clear_all = 1'b0;
    clear_in  = 1'b0;
    step_in   = 1'b0;
    step_out  = 1'b0;
    capture   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          clear_all = 1'b1;
          state_n   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clear_in = 1'b1;
        state_n  = ST_FEED;
      end
      ST_FEED: begin
        step_in = 1'b1;
        if (last_in) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ret_last) begin
          capture = 1'b1;
          if (last_out) begin
            state_n = ST_DONE;
          end else begin
            step_out = 1'b1;
            state_n  = ST_CLEAR;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Issue strobe delayed to line up with BRAM data; a shadow of the core pipe
  // tracks operands still in flight so the accumulator clear never flushes one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe     <= '0;
      flight_pipe <= '0;
      ret_cnt     <= '0;
      res_we_o    <= 1'b0;
      res_addr_o  <= '0;
      res_data_o  <= '0;
    end else begin
      rd_pipe     <= (rd_pipe << 1) | BRAM_LATENCY'(issue);
      flight_pipe <= (flight_pipe << 1) | CORE_LATENCY'(core_valid_o);
      if (clear_in) begin
        ret_cnt <= '0;
      end else if (count_en) begin
        ret_cnt <= ret_cnt + 1'b1;
      end
      res_we_o <= capture;
      if (capture) begin
        res_addr_o <= out_idx;
        res_data_o <= core_result_i;
      end
    end
  end

  assign core_valid_o  = rd_pipe[BRAM_LATENCY-1];
  assign core_run_o    = (state == ST_CLEAR) && !core_valid_o && !(|flight_pipe);
  assign busy_o        = (state != ST_IDLE);
  assign done_o        = (state == ST_DONE);
  assign node_addr_o   = in_idx;
  assign weight_addr_o = w_ptr;
  assign core_node_o   = node_rdata_i;
  assign core_weight_o = weight_rdata_i;

endmodule

// File: tb/tb_fc_layer_controller.sv
// Scoreboard bench for fc_layer_controller with BRAM and MAC core models (4x2 and 1x3 layers).
module tb_fc_layer_controller;
  import fc_ctrl_pkg::*;

  localparam int W      = 8;
  localparam int RW     = 4 * W;
  localparam int A_IN   = 4;
  localparam int A_OUT  = 2;
  localparam int A_NAW  = clog2w(A_IN);
  localparam int A_WAW  = clog2w(A_IN * A_OUT);
  localparam int A_RAW  = clog2w(A_OUT);
  localparam int B_IN   = 1;
  localparam int B_OUT  = 3;
  localparam int B_NAW  = clog2w(B_IN);
  localparam int B_WAW  = clog2w(B_IN * B_OUT);
  localparam int B_RAW  = clog2w(B_OUT);
  localparam int BOUND  = 200;

  typedef struct {
    int            addr;
    logic [RW-1:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;
  int a_writes = 0, a_dones = 0, b_writes = 0, b_dones = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: 4 inputs x 2 outputs ----------------
  logic a_start = 1'b0, a_busy, a_done, a_run, a_cvo, a_cvi, a_we;
  logic [A_NAW-1:0] a_node_addr;
  logic [A_WAW-1:0] a_weight_addr;
  logic [A_RAW-1:0] a_res_addr;
  logic [W-1:0]     a_node_rdata, a_weight_rdata, a_cn, a_cw;
  logic [RW-1:0]    a_result, a_res_data;

  fc_layer_controller #(
    .IN_DATA_WIDTH (W), .IN_NODE (A_IN), .OUT_NODE (A_OUT),
    .NODE_AW (A_NAW), .WEIGHT_AW (A_WAW), .RES_AW (A_RAW)
  ) dut_a (
    .clk (clk), .reset_n (reset_n), .start_i (a_start),
    .busy_o (a_busy), .done_o (a_done),
    .node_addr_o (a_node_addr), .node_rdata_i (a_node_rdata),
    .weight_addr_o (a_weight_addr), .weight_rdata_i (a_weight_rdata),
    .core_run_o (a_run), .core_valid_o (a_cvo),
    .core_node_o (a_cn), .core_weight_o (a_cw),
    .core_valid_i (a_cvi), .core_result_i (a_result),
    .res_we_o (a_we), .res_addr_o (a_res_addr), .res_data_o (a_res_data)
  );

  logic [W-1:0]  a_node_mem   [2**A_NAW];
  logic [W-1:0]  a_weight_mem [2**A_WAW];
  logic [RW-1:0] a_res_mem    [2**A_RAW];
  logic          a_v1, a_v2;
  logic [2*W-1:0] a_p1;
  logic [RW-1:0] a_acc;

  always @(posedge clk) begin
    a_node_rdata   <= a_node_mem[a_node_addr];
    a_weight_rdata <= a_weight_mem[a_weight_addr];
    if (a_we) a_res_mem[a_res_addr] <= a_res_data;
  end

  // Core model: run clears accumulator and valid pipe; product stage then accumulate stage.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_v1 <= 1'b0; a_v2 <= 1'b0; a_p1 <= '0; a_acc <= '0;
    end else if (a_run) begin
      a_v1 <= 1'b0; a_v2 <= 1'b0; a_acc <= '0;
    end else begin
      a_v1 <= a_cvo;
      a_p1 <= a_cn * a_cw;
      a_v2 <= a_v1;
      if (a_v1) a_acc <= a_acc + RW'(a_p1);
    end
  end
  assign a_cvi    = a_v2;
  assign a_result = a_acc;

  // ---------------- instance B: 1 input x 3 outputs ----------------
  logic b_start = 1'b0, b_busy, b_done, b_run, b_cvo, b_cvi, b_we;
  logic [B_NAW-1:0] b_node_addr;
  logic [B_WAW-1:0] b_weight_addr;
  logic [B_RAW-1:0] b_res_addr;
  logic [W-1:0]     b_node_rdata, b_weight_rdata, b_cn, b_cw;
  logic [RW-1:0]    b_result, b_res_data;

  fc_layer_controller #(
    .IN_DATA_WIDTH (W), .IN_NODE (B_IN), .OUT_NODE (B_OUT),
    .NODE_AW (B_NAW), .WEIGHT_AW (B_WAW), .RES_AW (B_RAW)
  ) dut_b (
    .clk (clk), .reset_n (reset_n), .start_i (b_start),
    .busy_o (b_busy), .done_o (b_done),
    .node_addr_o (b_node_addr), .node_rdata_i (b_node_rdata),
    .weight_addr_o (b_weight_addr), .weight_rdata_i (b_weight_rdata),
    .core_run_o (b_run), .core_valid_o (b_cvo),
    .core_node_o (b_cn), .core_weight_o (b_cw),
    .core_valid_i (b_cvi), .core_result_i (b_result),
    .res_we_o (b_we), .res_addr_o (b_res_addr), .res_data_o (b_res_data)
  );

  logic [W-1:0]  b_node_mem   [2**B_NAW];
  logic [W-1:0]  b_weight_mem [2**B_WAW];
  logic [RW-1:0] b_res_mem    [2**B_RAW];
  logic          b_v1, b_v2;
  logic [2*W-1:0] b_p1;
  logic [RW-1:0] b_acc;

  always @(posedge clk) begin
    b_node_rdata   <= b_node_mem[b_node_addr];
    b_weight_rdata <= b_weight_mem[b_weight_addr];
    if (b_we) b_res_mem[b_res_addr] <= b_res_data;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_v1 <= 1'b0; b_v2 <= 1'b0; b_p1 <= '0; b_acc <= '0;
    end else if (b_run) begin
      b_v1 <= 1'b0; b_v2 <= 1'b0; b_acc <= '0;
    end else begin
      b_v1 <= b_cvo;
      b_p1 <= b_cn * b_cw;
      b_v2 <= b_v1;
      if (b_v1) b_acc <= b_acc + RW'(b_p1);
    end
  end
  assign b_cvi    = b_v2;
  assign b_result = b_acc;

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      a_writes++;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_write: addr=%0d data=%0d, no write expected", a_res_addr, a_res_data);
      end else begin
        exp_t e;
        e = qa.pop_front();
        if (32'(a_res_addr) !== e.addr || a_res_data !== e.data) begin
          errors++;
          $display("FAIL a_result_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   a_res_addr, a_res_data, e.addr, e.data);
        end
      end
    end
    if (a_done === 1'b1) a_dones++;
    if (a_run === 1'b1) begin
      checks++;
      if (a_cvo !== 1'b0 || a_v1 !== 1'b0 || a_v2 !== 1'b0) begin
        errors++;
        $display("FAIL a_run_safety: run with operand in flight (valid=%b pipe=%b%b), expected none",
                 a_cvo, a_v1, a_v2);
      end
    end
    if (b_we === 1'b1) begin
      b_writes++;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_write: addr=%0d data=%0d, no write expected", b_res_addr, b_res_data);
      end else begin
        exp_t e;
        e = qb.pop_front();
        if (32'(b_res_addr) !== e.addr || b_res_data !== e.data) begin
          errors++;
          $display("FAIL b_result_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   b_res_addr, b_res_data, e.addr, e.data);
        end
      end
    end
    if (b_done === 1'b1) b_dones++;
    if (b_run === 1'b1) begin
      checks++;
      if (b_cvo !== 1'b0 || b_v1 !== 1'b0 || b_v2 !== 1'b0) begin
        errors++;
        $display("FAIL b_run_safety: run with operand in flight (valid=%b pipe=%b%b), expected none",
                 b_cvo, b_v1, b_v2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_a();
    for (int o = 0; o < A_OUT; o++) begin
      logic [RW-1:0] acc;
      acc = '0;
      for (int i = 0; i < A_IN; i++)
        acc = acc + RW'(a_node_mem[i]) * RW'(a_weight_mem[o * A_IN + i]);
      qa.push_back('{addr: o, data: acc});
    end
  endtask

  task automatic push_b();
    for (int o = 0; o < B_OUT; o++) begin
      logic [RW-1:0] acc;
      acc = '0;
      for (int i = 0; i < B_IN; i++)
        acc = acc + RW'(b_node_mem[i]) * RW'(b_weight_mem[o * B_IN + i]);
      qb.push_back('{addr: o, data: acc});
    end
  endtask

  task automatic load_basic();
    logic [W-1:0] wts [8];
    wts = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 8'd1, 8'd3};
    for (int i = 0; i < A_IN; i++) a_node_mem[i] = W'(i + 1);
    for (int i = 0; i < A_IN * A_OUT; i++) a_weight_mem[i] = wts[i];
  endtask

  // Leaves the caller at the negedge of the CLEAR cycle (cycle 1 after start is sampled).
  task automatic pulse_start_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (a_done !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      checks++;
      errors++;
      $display("FAIL a_done_timeout: no done_o within %0d cycles", BOUND);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_run, a_cvo, a_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy,done,run,valid,we=%b, expected 00000",
               {a_busy, a_done, a_run, a_cvo, a_we});
    end
    checks++;
    if (a_node_addr !== '0 || a_weight_addr !== '0 || a_res_addr !== '0 || a_res_data !== '0) begin
      errors++;
      $display("FAIL reset_addr: node=%0d weight=%0d res=%0d data=%0d, expected all 0",
               a_node_addr, a_weight_addr, a_res_addr, a_res_data);
    end
    checks++;
    if ({b_busy, b_done, b_run, b_cvo, b_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl_b: busy,done,run,valid,we=%b, expected 00000",
               {b_busy, b_done, b_run, b_cvo, b_we});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_run, a_we} !== 4'b0) begin
      errors++;
      $display("FAIL idle_hold: busy,done,run,we=%b without start, expected 0000",
               {a_busy, a_done, a_run, a_we});
    end
  endtask

  task automatic test_basic_sweep();
    int n, w0, d0;
    load_basic();
    push_a();
    w0 = a_writes; d0 = a_dones;
    pulse_start_a();
    wait_done_a(n);
    checks++;
    if (n + 1 !== 17) begin
      errors++;
      $display("FAIL basic_latency: done_o %0d cycles after start, expected 17", n + 1);
    end
    @(negedge clk);
    checks++;
    if (a_res_mem[0] !== 32'd10 || a_res_mem[1] !== 32'd17) begin
      errors++;
      $display("FAIL basic_results: mem0=%0d mem1=%0d, expected 10 and 17", a_res_mem[0], a_res_mem[1]);
    end
    checks++;
    if (a_writes - w0 !== 2 || a_dones - d0 !== 1 || qa.size() !== 0) begin
      errors++;
      $display("FAIL basic_counts: writes=%0d dones=%0d pending=%0d, expected 2 1 0",
               a_writes - w0, a_dones - d0, qa.size());
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_end: busy=%b after done, expected 0", a_busy);
    end
  endtask

  task automatic test_max_operands();
    int n;
    for (int i = 0; i < A_IN; i++) a_node_mem[i] = 8'hFF;
    for (int i = 0; i < A_IN * A_OUT; i++) a_weight_mem[i] = 8'hFF;
    push_a();
    pulse_start_a();
    wait_done_a(n);
    @(negedge clk);
    checks++;
    if (a_res_mem[0] !== 32'd260100 || a_res_mem[1] !== 32'd260100) begin
      errors++;
      $display("FAIL max_operands: mem0=%0d mem1=%0d, expected 260100", a_res_mem[0], a_res_mem[1]);
    end
    checks++;
    if (qa.size() !== 0) begin
      errors++;
      $display("FAIL max_pending: %0d results outstanding, expected 0", qa.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, w0;
    load_basic();
    push_a();
    w0 = a_writes;
    pulse_start_a();
    repeat (14) @(negedge clk);  // cycle 15: DRAIN of neuron 1
    checks++;
    if (a_busy !== 1'b1 || a_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_precondition: busy=%b we=%b before reset, expected 1 0", a_busy, a_we);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_run, a_cvo, a_we} !== 5'b0 || a_res_data !== '0 ||
        a_node_addr !== '0 || a_weight_addr !== '0 || a_res_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ctrl=%b data=%0d addrs=%0d/%0d/%0d, expected all 0",
               {a_busy, a_done, a_run, a_cvo, a_we}, a_res_data, a_node_addr, a_weight_addr, a_res_addr);
    end
    @(negedge clk);
    checks++;
    if (a_writes - w0 !== 1 || qa.size() !== 1) begin
      errors++;
      $display("FAIL mid_no_write: writes=%0d pending=%0d, expected 1 1", a_writes - w0, qa.size());
    end
    checks++;
    if (a_res_mem[0] !== 32'd10 || a_res_mem[1] !== 32'd260100) begin
      errors++;
      $display("FAIL mid_mem_kept: mem0=%0d mem1=%0d, expected 10 and 260100", a_res_mem[0], a_res_mem[1]);
    end
    qa.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    push_a();
    pulse_start_a();
    wait_done_a(n);
    @(negedge clk);
    checks++;
    if (a_res_mem[0] !== 32'd10 || a_res_mem[1] !== 32'd17 || qa.size() !== 0) begin
      errors++;
      $display("FAIL mid_rerun: mem0=%0d mem1=%0d pending=%0d, expected 10 17 0",
               a_res_mem[0], a_res_mem[1], qa.size());
    end
  endtask

  task automatic test_start_while_busy();
    int n, w0, d0;
    load_basic();
    push_a();
    w0 = a_writes; d0 = a_dones;
    pulse_start_a();
    @(negedge clk) a_start = 1'b1;  // FEED of neuron 0
    @(negedge clk) a_start = 1'b0;
    wait_done_a(n);
    repeat (30) @(negedge clk);
    checks++;
    if (a_writes - w0 !== 2 || a_dones - d0 !== 1) begin
      errors++;
      $display("FAIL busy_start: writes=%0d dones=%0d, expected 2 1", a_writes - w0, a_dones - d0);
    end
    checks++;
    if (a_busy !== 1'b0 || qa.size() !== 0) begin
      errors++;
      $display("FAIL busy_start_idle: busy=%b pending=%0d, expected 0 0", a_busy, qa.size());
    end
  endtask

  task automatic test_back_to_back();
    int n, w0, d0;
    load_basic();
    push_a();
    push_a();
    w0 = a_writes; d0 = a_dones;
    pulse_start_a();
    wait_done_a(n);
    @(negedge clk) a_start = 1'b1;  // cycle after done_o
    @(negedge clk) a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_run !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b run=%b, expected 1 1", a_busy, a_run);
    end
    @(negedge clk);
    checks++;
    if (a_weight_addr !== '0 || a_node_addr !== '0) begin
      errors++;
      $display("FAIL b2b_ptr_restart: weight_addr=%0d node_addr=%0d, expected 0 0", a_weight_addr, a_node_addr);
    end
    wait_done_a(n);
    @(negedge clk);
    checks++;
    if (a_writes - w0 !== 4 || a_dones - d0 !== 2 || qa.size() !== 0) begin
      errors++;
      $display("FAIL b2b_counts: writes=%0d dones=%0d pending=%0d, expected 4 2 0",
               a_writes - w0, a_dones - d0, qa.size());
    end
  endtask

  task automatic test_single_input();
    int k, last, w0;
    b_node_mem[0] = 8'd7;
    b_node_mem[1] = 8'd0;
    b_weight_mem[0] = 8'd3;
    b_weight_mem[1] = 8'd5;
    b_weight_mem[2] = 8'd255;
    b_weight_mem[3] = 8'd0;
    push_b();
    w0 = b_writes;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    k = 1;
    last = -1;
    while (k < BOUND) begin
      if (b_we === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (k - last !== 5) begin
            errors++;
            $display("FAIL single_period: %0d cycles between writes, expected 5", k - last);
          end
        end
        last = k;
      end
      if (b_done === 1'b1) break;
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 16) begin
      errors++;
      $display("FAIL single_latency: done_o %0d cycles after start, expected 16", k);
    end
    @(negedge clk);
    checks++;
    if (b_res_mem[0] !== 32'd21 || b_res_mem[1] !== 32'd35 || b_res_mem[2] !== 32'd1785) begin
      errors++;
      $display("FAIL single_results: %0d %0d %0d, expected 21 35 1785",
               b_res_mem[0], b_res_mem[1], b_res_mem[2]);
    end
    checks++;
    if (b_writes - w0 !== 3 || qb.size() !== 0) begin
      errors++;
      $display("FAIL single_counts: writes=%0d pending=%0d, expected 3 0", b_writes - w0, qb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2**A_NAW; i++) a_node_mem[i] = '0;
    for (int i = 0; i < 2**A_WAW; i++) a_weight_mem[i] = '0;
    for (int i = 0; i < 2**B_NAW; i++) b_node_mem[i] = '0;
    for (int i = 0; i < 2**B_WAW; i++) b_weight_mem[i] = '0;
    test_reset();
    test_basic_sweep();
    test_max_operands();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_single_input();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
